// File: rtl/multicycle_control_unit.sv
// ============================================================================
// Module     : multicycle_control_unit
// Description: Fetch/decode sequencer for the multicycle processor. Drives the
//              IF/ID/EX/MEM/WB phases, ALU controls and datapath strobes.
//              Optional macro ILLEGAL_TRAP_EN: unsupported R/S ops halt.
// Revision   : 1.0 - initial release
// ============================================================================
`default_nettype none

module multicycle_control_unit #(
    parameter int              PC_W   = 32,
    parameter logic [PC_W-1:0] RST_PC = '0
) (
    input  logic            clk,
    input  logic            reset_n,
    output logic            imem_req,
    input  logic            imem_ack,
    input  logic [31:0]     imem_data,
    input  logic            zero_flag,
    output logic [PC_W-1:0] pc,
    output logic [4:0]      alu_func,
    output logic [1:0]      alu_typ,
    output logic [13:0]     immd14,
    output logic [3:0]      rs1,
    output logic [3:0]      rs2,
    output logic [3:0]      rd,
    output logic            reg_write,
    output logic            mem_read,
    output logic            mem_write,
    output logic            halted
);

    typedef enum logic [2:0] {
        S_IF   = 3'd0,
        S_ID   = 3'd1,
        S_EX   = 3'd2,
        S_MEM  = 3'd3,
        S_WB   = 3'd4,
        S_HALT = 3'd5
    } state_t;

    localparam logic [1:0]      c_IT_R     = 2'b00;
    localparam logic [1:0]      c_IT_J     = 2'b01;
    localparam logic [1:0]      c_IT_I     = 2'b10;
    localparam logic [1:0]      c_IT_S     = 2'b11;
    localparam logic [4:0]      c_F_LW     = 5'b00011;
    localparam logic [4:0]      c_F_SW     = 5'b00100;
    localparam logic [4:0]      c_F_BEQ    = 5'b00101;
    localparam logic [PC_W-1:0] c_PC_STEP  = PC_W'(4);

    state_t      r_state;
    logic [31:0] r_ir;

    logic [4:0]      w_func;
    logic [1:0]      w_itype;
    logic            w_stop;
    logic            w_is_beq;
    logic            w_is_lw;
    logic            w_is_sw;
    logic            w_illegal;
    logic [1:0]      w_alu_typ;
    logic [PC_W-1:0] w_j_off;
    logic [PC_W-1:0] w_b_off;
    logic [PC_W-1:0] w_pc_plus4;

    assign w_func     = r_ir[31:27];
    assign w_itype    = r_ir[2:1];
    assign w_stop     = r_ir[0];
    assign w_is_beq   = (w_itype == c_IT_I) && (w_func == c_F_BEQ);
    assign w_is_lw    = (w_itype == c_IT_I) && (w_func == c_F_LW);
    assign w_is_sw    = (w_itype == c_IT_I) && (w_func == c_F_SW);
    assign w_illegal  = ((w_itype == c_IT_S) && (w_func != 5'b00000) && (w_func != 5'b00010))
                     || ((w_itype == c_IT_R) && (w_func > 5'b00010));
    // Branch/jump offsets are word offsets, sign-extended then scaled to bytes
    assign w_j_off    = {{(PC_W-26){r_ir[26]}}, r_ir[26:3], 2'b00};
    assign w_b_off    = {{(PC_W-16){r_ir[16]}}, r_ir[16:3], 2'b00};
    assign w_pc_plus4 = pc + c_PC_STEP;

    always_comb begin
        w_alu_typ = 2'b00;
        case (w_itype)
            c_IT_S:  w_alu_typ = 2'b01;
            c_IT_I:  w_alu_typ = 2'b10;
            default: w_alu_typ = 2'b00;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= S_IF;
            r_ir      <= '0;
            pc        <= RST_PC;
            imem_req  <= 1'b0;
            alu_func  <= '0;
            alu_typ   <= '0;
            immd14    <= '0;
            rs1       <= '0;
            rs2       <= '0;
            rd        <= '0;
            reg_write <= 1'b0;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            halted    <= 1'b0;
        end else begin
            reg_write <= 1'b0;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            case (r_state)
                S_IF: begin
                    if (imem_req && imem_ack) begin
                        r_ir     <= imem_data;
                        imem_req <= 1'b0;
                        r_state  <= S_ID;
                    end else begin
                        imem_req <= 1'b1;
                    end
                end
                S_ID: begin
                    alu_func <= w_func;
                    alu_typ  <= w_alu_typ;
                    immd14   <= r_ir[16:3];
                    rs1      <= r_ir[26:23];
                    rd       <= r_ir[22:19];
                    rs2      <= r_ir[18:15];
                    if (w_itype == c_IT_J) begin
                        pc <= pc + w_j_off;
                        if (w_stop) begin
                            r_state <= S_HALT;
                            halted  <= 1'b1;
                        end else begin
                            r_state  <= S_IF;
                            imem_req <= 1'b1;
                        end
                    end else if (w_illegal) begin
`ifdef ILLEGAL_TRAP_EN
                        r_state <= S_HALT;
                        halted  <= 1'b1;
`else
                        pc       <= w_pc_plus4;
                        r_state  <= S_IF;
                        imem_req <= 1'b1;
`endif
                    end else begin
                        r_state <= S_EX;
                    end
                end
                S_EX: begin
                    if (w_is_beq) begin
                        pc <= zero_flag ? (w_pc_plus4 + w_b_off) : w_pc_plus4;
                        if (w_stop) begin
                            r_state <= S_HALT;
                            halted  <= 1'b1;
                        end else begin
                            r_state  <= S_IF;
                            imem_req <= 1'b1;
                        end
                    end else if (w_is_lw || w_is_sw) begin
                        r_state <= S_MEM;
                    end else begin
                        r_state <= S_WB;
                    end
                end
                S_MEM: begin
                    if (w_is_lw) begin
                        mem_read <= 1'b1;
                        r_state  <= S_WB;
                    end else begin
                        mem_write <= 1'b1;
                        pc        <= w_pc_plus4;
                        if (w_stop) begin
                            r_state <= S_HALT;
                            halted  <= 1'b1;
                        end else begin
                            r_state  <= S_IF;
                            imem_req <= 1'b1;
                        end
                    end
                end
                S_WB: begin
                    reg_write <= 1'b1;
                    pc        <= w_pc_plus4;
                    if (w_stop) begin
                        r_state <= S_HALT;
                        halted  <= 1'b1;
                    end else begin
                        r_state  <= S_IF;
                        imem_req <= 1'b1;
                    end
                end
                S_HALT: begin
                    halted   <= 1'b1;
                    imem_req <= 1'b0;
                end
                default: begin
                    r_state <= S_IF;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_multicycle_control_unit.sv
// ============================================================================
// Module     : tb_multicycle_control_unit
// Description: Self-checking bench for multicycle_control_unit (vector table
//              plus hand-written multi-cycle sequences).
// Revision   : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_multicycle_control_unit;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_data = '0;
    logic        zero_flag = 1'b0;
    logic        imem_req;
    logic [31:0] pc;
    logic [4:0]  alu_func;
    logic [1:0]  alu_typ;
    logic [13:0] immd14;
    logic [3:0]  rs1, rs2, rd;
    logic        reg_write, mem_read, mem_write, halted;

    multicycle_control_unit #(.PC_W(32), .RST_PC(32'h0)) dut (
        .clk(clk), .reset_n(reset_n), .imem_req(imem_req), .imem_ack(imem_ack),
        .imem_data(imem_data), .zero_flag(zero_flag), .pc(pc), .alu_func(alu_func),
        .alu_typ(alu_typ), .immd14(immd14), .rs1(rs1), .rs2(rs2), .rd(rd),
        .reg_write(reg_write), .mem_read(mem_read), .mem_write(mem_write), .halted(halted)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic        zf;
        int          dly;
    } vec_t;

    typedef struct {
        logic [31:0] pc;
        logic        halted;
        int          lat;
        int          rw_at;
        int          mr_at;
        int          mw_at;
        logic [4:0]  func;
        logic [1:0]  typ;
        logic [13:0] imm;
        logic [3:0]  rs1, rs2, rd;
    } exp_t;

    exp_t        sb[$];
    int          tests = 0;
    int          fails = 0;
    logic [31:0] m_pc = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] enc(input logic [4:0] f, input logic [3:0] a,
                                        input logic [3:0] d, input logic [3:0] b,
                                        input logic [13:0] im, input logic [1:0] it,
                                        input logic st);
        logic [31:0] w;
        w = '0;
        w[31:27] = f;
        w[26:23] = a;
        w[22:19] = d;
        w[18:15] = b;
        w[16:3]  = w[16:3] | im;
        w[2:1]   = it;
        w[0]     = st;
        return w;
    endfunction

    function automatic logic [31:0] encj(input logic [23:0] im, input logic st);
        return {5'b00000, im, 2'b01, st};
    endfunction

    // Reference behaviour of one instruction, starting from pc = cur
    function automatic exp_t model(input logic [31:0] ins, input logic zf, input logic [31:0] cur);
        exp_t        e;
        logic [4:0]  f;
        logic [1:0]  it;
        logic [31:0] s24, s14;
        f   = ins[31:27];
        it  = ins[2:1];
        s24 = {{6{ins[26]}}, ins[26:3], 2'b00};
        s14 = {{16{ins[16]}}, ins[16:3], 2'b00};
        e.func = f; e.rs1 = ins[26:23]; e.rd = ins[22:19]; e.rs2 = ins[18:15];
        e.imm  = ins[16:3];
        e.typ  = (it == 2'b11) ? 2'b01 : (it == 2'b10) ? 2'b10 : 2'b00;
        e.rw_at = 0; e.mr_at = 0; e.mw_at = 0;
        e.halted = ins[0];
        if (it == 2'b01) begin
            e.pc = cur + s24; e.lat = 2;
        end else if ((it == 2'b11 && f != 5'd0 && f != 5'd2) || (it == 2'b00 && f > 5'd2)) begin
            e.lat = 2;
`ifdef ILLEGAL_TRAP_EN
            e.pc = cur; e.halted = 1'b1;
`else
            e.pc = cur + 32'd4; e.halted = 1'b0;
`endif
        end else if (it == 2'b10 && f == 5'd5) begin
            e.pc = zf ? cur + 32'd4 + s14 : cur + 32'd4; e.lat = 3;
        end else if (it == 2'b10 && f == 5'd3) begin
            e.pc = cur + 32'd4; e.lat = 5; e.mr_at = 4; e.rw_at = 5;
        end else if (it == 2'b10 && f == 5'd4) begin
            e.pc = cur + 32'd4; e.lat = 4; e.mw_at = 4;
        end else begin
            e.pc = cur + 32'd4; e.lat = 4; e.rw_at = 4;
        end
        return e;
    endfunction

    // Fetch one instruction (ack after dly cycles) and observe it to completion
    task automatic exec(input logic [31:0] ins, input logic zf, input int dly);
        exp_t e, got;
        int   n, w, c_rw, c_mr, c_mw;
        bit   req_ok;
        sb.push_back(model(ins, zf, m_pc));
        zero_flag = zf;
        w = 0;
        while (!imem_req && w < 10) begin
            @(negedge clk);
            w++;
        end
        check("req_wait", {63'd0, imem_req}, 64'd1);
        req_ok = 1'b1;
        repeat (dly) begin
            @(negedge clk);
            if (!imem_req || reg_write || mem_read || mem_write || pc !== m_pc) req_ok = 1'b0;
        end
        if (dly > 0) check("ack_wait_hold", {63'd0, req_ok}, 64'd1);
        imem_data = ins;
        imem_ack  = 1'b1;
        got.rw_at = 0; got.mr_at = 0; got.mw_at = 0;
        c_rw = 0; c_mr = 0; c_mw = 0;
        for (n = 1; n <= 20; n++) begin
            @(negedge clk);
            imem_ack  = 1'b0;
            imem_data = 32'hDEAD_BEEF;
            if (reg_write) begin c_rw++; got.rw_at = (c_rw == 1) ? n : 99; end
            if (mem_read)  begin c_mr++; got.mr_at = (c_mr == 1) ? n : 99; end
            if (mem_write) begin c_mw++; got.mw_at = (c_mw == 1) ? n : 99; end
            if (imem_req || halted) break;
        end
        got.lat = n; got.pc = pc; got.halted = halted;
        got.func = alu_func; got.typ = alu_typ; got.imm = immd14;
        got.rs1 = rs1; got.rs2 = rs2; got.rd = rd;
        e = sb.pop_front();
        check("pc", {32'd0, got.pc}, {32'd0, e.pc});
        check("timing_strobes", {got.lat[7:0], got.rw_at[7:0], got.mr_at[7:0], got.mw_at[7:0]},
                                {e.lat[7:0], e.rw_at[7:0], e.mr_at[7:0], e.mw_at[7:0]});
        check("fields", {got.func, got.typ, got.imm, got.rs1, got.rs2, got.rd},
                        {e.func, e.typ, e.imm, e.rs1, e.rs2, e.rd});
        check("halted", {63'd0, got.halted}, {63'd0, e.halted});
        m_pc = e.pc;
    endtask

    task automatic do_reset();
        reset_n  = 1'b0;
        imem_ack = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_state", {pc, imem_req, reg_write, mem_read, mem_write, halted,
                              alu_func, alu_typ, immd14, rs1, rs2, rd}, 64'd0);
        reset_n = 1'b1;
        m_pc = '0;
        sb.delete();
    endtask

    vec_t vt[14];
    logic [31:0] add_ins;

    initial begin
        add_ins = 32'h0898_0000;
        vt[0]  = '{add_ins, 1'b0, 0};                                              // ADD     -> 04
        vt[1]  = '{enc(5'd2, 4'd5, 4'd6, 4'd7, 14'd0, 2'b00, 1'b0), 1'b0, 0};     // R func2 -> 08
        vt[2]  = '{enc(5'd0, 4'd1, 4'd2, 4'd0, 14'h2AB5, 2'b11, 1'b0), 1'b0, 0};  // S func0 -> 0C
        vt[3]  = '{enc(5'd1, 4'd9, 4'd4, 4'd0, 14'h0123, 2'b10, 1'b0), 1'b1, 0};  // I ADDI  -> 10
        vt[4]  = '{enc(5'd5, 4'd1, 4'd2, 4'd0, 14'h3FFE, 2'b10, 1'b0), 1'b1, 0};  // BEQ tk  -> 0C
        vt[5]  = '{enc(5'd5, 4'd1, 4'd2, 4'd0, 14'h3FFE, 2'b10, 1'b0), 1'b0, 0};  // BEQ nt  -> 10
        vt[6]  = '{enc(5'd5, 4'd3, 4'd4, 4'd0, 14'h3FFE, 2'b10, 1'b0), 1'b0, 1};  // BEQ nt  -> 14
        vt[7]  = '{enc(5'd3, 4'd2, 4'd8, 4'd0, 14'd8, 2'b10, 1'b0), 1'b0, 0};     // LW      -> 18
        vt[8]  = '{enc(5'd4, 4'd2, 4'd8, 4'd0, 14'h3FFF, 2'b10, 1'b0), 1'b0, 0};  // SW      -> 1C
        vt[9]  = '{encj(24'hFFFFF9, 1'b0), 1'b0, 0};                              // J -7    -> 00
        vt[10] = '{encj(24'h000003, 1'b0), 1'b0, 0};                              // J +3    -> 0C
        vt[11] = '{enc(5'd2, 4'd15, 4'd14, 4'd0, 14'h1001, 2'b11, 1'b0), 1'b0, 2};// S func2 -> 10
        vt[12] = '{enc(5'd5, 4'd0, 4'd0, 4'd0, 14'd5, 2'b10, 1'b0), 1'b1, 0};     // BEQ +5  -> 28
        vt[13] = '{enc(5'd7, 4'd6, 4'd7, 4'd0, 14'h2000, 2'b10, 1'b0), 1'b0, 3};  // I other -> 2C

        repeat (2) @(negedge clk);
        do_reset();
        for (int i = 0; i < 14; i++) exec(vt[i].instr, vt[i].zf, vt[i].dly);

        // fetch stalled by a slow memory
        exec(add_ins, 1'b0, 5);

        // reset while in EX abandons the instruction immediately
        begin
            int w;
            w = 0;
            while (!imem_req && w < 10) begin @(negedge clk); w++; end
            imem_data = add_ins;
            imem_ack  = 1'b1;
            @(negedge clk);
            imem_ack = 1'b0;
            @(negedge clk);
            #2 reset_n = 1'b0;
            #1 check("reset_mid_ex", {31'd0, pc, imem_req}, 64'd0);
            @(negedge clk);
            reset_n = 1'b1;
            m_pc = '0;
        end
        exec(add_ins, 1'b0, 0);

        // unsupported R function
        exec(enc(5'h1F, 4'd1, 4'd2, 4'd3, 14'd0, 2'b00, 1'b0), 1'b0, 0);
        do_reset();

        // jump backward across zero, then forward wrap back to zero
        exec(encj(24'hFFFFFF, 1'b0), 1'b0, 0);
        exec(encj(24'h000001, 1'b0), 1'b0, 0);

        // stop on ADD: absorbing halt, stray acks ignored
        exec(add_ins | 32'd1, 1'b0, 0);
        begin
            bit quiet;
            quiet = 1'b1;
            imem_ack = 1'b1;
            repeat (20) begin
                @(negedge clk);
                if (imem_req || reg_write || mem_read || mem_write || !halted || pc !== m_pc)
                    quiet = 1'b0;
            end
            imem_ack = 1'b0;
            check("halt_absorbing", {63'd0, quiet}, 64'd1);
        end

        // stop on a taken BEQ halts after its PC update
        do_reset();
        exec(enc(5'd5, 4'd0, 4'd0, 4'd0, 14'h3FFE, 2'b10, 1'b1), 1'b1, 0);
        do_reset();
        exec(enc(5'd4, 4'd1, 4'd1, 4'd0, 14'd4, 2'b10, 1'b1), 1'b0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", tests, fails);
        $fatal(1);
    end

endmodule

`default_nettype wire
